// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and the alignment rule for the load/store sequencer.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_t;

  // Reserved size is folded in here so the FSM only has one error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake of the load/store sequencer.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );

endinterface

// File: rtl/lane_align.sv
// Little-endian byte-lane steering: load extraction with sign/zero extension,
// and store merge of a sub-word into the word read back from RAM.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit_byte;
      logic hit_half;
      logic hit_word;

      assign lanes[gi] = rdata[8*gi +: 8];
      assign hit_byte  = (size == SZ_BYTE) && (offset == LANE);
      assign hit_half  = (size == SZ_HALF) && (offset[1] == LANE[1]);
      assign hit_word  = (size == SZ_WORD);

      // A half store places wdata[7:0] in the even lane and wdata[15:8] in the odd lane.
      assign store_data[8*gi +: 8] = hit_byte ? wdata[7:0] :
                                     hit_half ? wdata[8*(gi%2) +: 8] :
                                     hit_word ? wdata[8*gi +: 8] :
                                                rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel  = lanes[offset];
  assign half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
  assign byte_sign = ~zero_ext & byte_sel[7];
  assign half_sign = ~zero_ext & half_sel[15];

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{byte_sign}}, byte_sel};
      SZ_HALF: load_data = {{16{half_sign}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: read-modify-write for sub-word stores, lane extraction
// for sub-word loads, and misalignment detection, over a word-wide sync RAM.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_reg, state_next;
  logic              write_reg, write_next;
  logic [1:0]        size_reg, size_next;
  logic              uns_reg, uns_next;
  logic [1:0]        off_reg, off_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_we_reg, mem_we_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              resp_valid_reg, resp_valid_next;
  logic              resp_err_reg, resp_err_next;
  logic [31:0]       resp_rdata_reg, resp_rdata_next;

  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic              unused_addr;

  // Address bits above the RAM depth wrap and are intentionally dropped.
  assign unused_addr = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  lane_align u_lane_align (
    .rdata      (mem_rdata),
    .offset     (off_reg),
    .size       (size_reg),
    .zero_ext   (uns_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_next      = state_reg;
    write_next      = write_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    off_next        = off_reg;
    wdata_next      = wdata_reg;
    mem_addr_next   = mem_addr_reg;
    mem_we_next     = 1'b0;
    mem_wdata_next  = mem_wdata_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = resp_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          write_next    = bus.req_write;
          size_next     = bus.req_size;
          uns_next      = bus.req_unsigned;
          off_next      = bus.req_addr[1:0];
          wdata_next    = bus.req_wdata;
          mem_addr_next = bus.req_addr[ADDR_W+1:2];
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
            state_next     = WR;
            mem_we_next    = 1'b1;
            mem_wdata_next = bus.req_wdata;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: state_next = WAIT;
      WAIT: begin
        // mem_rdata is valid this cycle only, so it is consumed here either way.
        if (write_reg) begin
          state_next     = WR;
          mem_we_next    = 1'b1;
          mem_wdata_next = store_data;
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = load_data;
        end
      end
      WR: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = '0;
      end
      RESP: begin
        state_next      = IDLE;
        resp_rdata_next = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      size_reg       <= SZ_BYTE;
      uns_reg        <= 1'b0;
      off_reg        <= 2'b00;
      wdata_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      write_reg      <= write_next;
      size_reg       <= size_next;
      uns_reg        <= uns_next;
      off_reg        <= off_next;
      wdata_reg      <= wdata_next;
      mem_addr_reg   <= mem_addr_next;
      mem_we_reg     <= mem_we_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_we         = mem_we_reg;
  assign mem_wdata      = mem_wdata_reg;

endmodule
